// File: rtl/ltssm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ltssm_pkg                                                      |
// | Description : Shared types and constants for the receive-side ordered-set    |
// |               detector and the LTSSM it feeds: K-code values, TS type        |
// |               encoding, TS identifier symbols and the captured field record. |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ltssm_pkg;

  // K codes that matter for ordered-set framing (8b value, sym_is_k=1).
  typedef enum logic [7:0] {
    K28_5 = 8'hBC,  // COM
    K28_3 = 8'h7C,  // IDL
    K23_7 = 8'hF7   // PAD
  } k_symbols_e;

  typedef enum logic [1:0] {
    TS_NONE  = 2'd0,
    TS_TYPE1 = 2'd1,
    TS_TYPE2 = 2'd2
  } ts_type_e;

  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  localparam int         TS_LEN = 16;

  // Symbols 1..5 of a training set, with PAD flags for link/lane.
  typedef struct packed {
    logic       link_pad;
    logic       lane_pad;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] ctrl;
  } ts_fields_t;

  // True when the symbol is the given K code.
  function automatic logic is_k_sym(input logic is_k, input logic [7:0] data,
                                    input k_symbols_e sym);
    return is_k && (data == sym);
  endfunction

endpackage : ltssm_pkg
`default_nettype wire

// File: rtl/ts_os_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ts_os_detect                                                   |
// | Description : Per-lane ordered-set detector. Parses decoded 8b symbols into  |
// |               TS1/TS2/EIOS events, captures TS fields and counts             |
// |               consecutive identical training sets for the LTSSM.             |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
// | Ports                                                                        |
// |   clk, rst        : core clock, asynchronous active-high reset               |
// |   sym_valid       : symbol qualifier, gaps allowed                           |
// |   sym_data/_is_k  : decoded symbol and K flag                                |
// |   sym_err         : decode/disparity error on this symbol                    |
// |   cnt_clr         : clear the consecutive-TS counter                         |
// |   ts_valid        : 1-cycle pulse, complete well-formed TS received          |
// |   ts_type         : type of last valid TS                                    |
// |   ts_link_pad/num : symbol 1 (PAD flag, data)                                |
// |   ts_lane_pad/num : symbol 2 (PAD flag, data)                                |
// |   ts_nfts/rate/ctrl : symbols 3, 4, 5                                        |
// |   consec_cnt/hit  : consecutive identical TS count and threshold flag        |
// |   eios_det        : 1-cycle pulse, COM IDL IDL IDL received                  |
// +----------------------------------------------------------------------------+
module ts_os_detect
  import ltssm_pkg::*;
#(
  parameter int CONSEC_TARGET = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [7:0]       sym_data,
  input  logic             sym_is_k,
  input  logic             sym_err,
  input  logic             cnt_clr,
  output logic             ts_valid,
  output logic [1:0]       ts_type,
  output logic             ts_link_pad,
  output logic [7:0]       ts_link_num,
  output logic             ts_lane_pad,
  output logic [7:0]       ts_lane_num,
  output logic [7:0]       ts_nfts,
  output logic [7:0]       ts_rate,
  output logic [7:0]       ts_ctrl,
  output logic [CNT_W-1:0] consec_cnt,
  output logic             consec_hit,
  output logic             eios_det
);

  localparam logic [1:0] c_st_hunt    = 2'd0;
  localparam logic [1:0] c_st_collect = 2'd1;
  localparam logic [1:0] c_st_eios    = 2'd2;

  localparam logic [3:0]       c_idx_last = 4'(TS_LEN - 1);
  localparam logic [CNT_W-1:0] c_target   = CNT_W'(CONSEC_TARGET);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Registered state
  logic [1:0]       r_state;
  logic [3:0]       r_idx;
  ts_fields_t       r_shadow;   // fields of the set currently being received
  logic [7:0]       r_id;       // TS identifier captured at symbol 6
  ts_fields_t       r_fields;   // fields of the last valid TS
  ts_type_e         r_ts_type;
  logic             r_ts_valid;
  logic             r_eios;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_cmp_ok;   // r_fields is a legal reference for "identical"

  // Next-state wires
  logic [1:0]       w_state_nxt;
  logic [3:0]       w_idx_nxt;
  ts_fields_t       w_shadow_nxt;
  logic [7:0]       w_id_nxt;
  logic             w_ts_done;
  logic             w_eios_done;
  logic             w_abort;
  logic             w_field_ok;
  ts_type_e         w_type_new;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cmp_ok_nxt;

  // Symbol classification
  logic w_com;
  logic w_idl;
  logic w_pad;
  logic w_dsym;

  assign w_com  = is_k_sym(sym_is_k, sym_data, K28_5);
  assign w_idl  = is_k_sym(sym_is_k, sym_data, K28_3);
  assign w_pad  = is_k_sym(sym_is_k, sym_data, K23_7);
  assign w_dsym = !sym_is_k;

  // Per-position legality of a symbol inside a TS body.
  always_comb begin
    w_field_ok = 1'b0;
    if (r_idx <= 4'd2) begin
      w_field_ok = w_dsym || w_pad;
    end else if (r_idx <= 4'd5) begin
      w_field_ok = w_dsym;
    end else if (r_idx == 4'd6) begin
      w_field_ok = w_dsym && ((sym_data == TS1_ID) || (sym_data == TS2_ID));
    end else begin
      w_field_ok = w_dsym && (sym_data == r_id);
    end
  end

  // Framing FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_id_nxt     = r_id;
    w_ts_done    = 1'b0;
    w_eios_done  = 1'b0;
    w_abort      = 1'b0;

    if (sym_valid) begin
      case (r_state)
        c_st_hunt: begin
          if (w_com && !sym_err) begin
            w_state_nxt = c_st_collect;
            w_idx_nxt   = 4'd1;
          end
        end

        c_st_collect, c_st_eios: begin
          if (sym_err) begin
            w_abort     = 1'b1;
            w_state_nxt = c_st_hunt;
            w_idx_nxt   = 4'd0;
          end else if (w_com) begin
            // A COM mid-set kills the current set but is itself a valid start.
            w_abort     = 1'b1;
            w_state_nxt = c_st_collect;
            w_idx_nxt   = 4'd1;
          end else if (r_state == c_st_eios) begin
            if (w_idl) begin
              if (r_idx == 4'd3) begin
                w_eios_done = 1'b1;
                w_state_nxt = c_st_hunt;
                w_idx_nxt   = 4'd0;
              end else begin
                w_idx_nxt = r_idx + 4'd1;
              end
            end else begin
              w_abort     = 1'b1;
              w_state_nxt = c_st_hunt;
              w_idx_nxt   = 4'd0;
            end
          end else if ((r_idx == 4'd1) && w_idl) begin
            w_state_nxt = c_st_eios;
            w_idx_nxt   = 4'd2;
          end else if (w_field_ok) begin
            case (r_idx)
              4'd1: begin
                w_shadow_nxt.link_pad = sym_is_k;
                w_shadow_nxt.link     = sym_data;
              end
              4'd2: begin
                w_shadow_nxt.lane_pad = sym_is_k;
                w_shadow_nxt.lane     = sym_data;
              end
              4'd3:    w_shadow_nxt.nfts = sym_data;
              4'd4:    w_shadow_nxt.rate = sym_data;
              4'd5:    w_shadow_nxt.ctrl = sym_data;
              4'd6:    w_id_nxt          = sym_data;
              default: ;
            endcase
            if (r_idx == c_idx_last) begin
              w_ts_done   = 1'b1;
              w_state_nxt = c_st_hunt;
              w_idx_nxt   = 4'd0;
            end else begin
              w_idx_nxt = r_idx + 4'd1;
            end
          end else begin
            w_abort     = 1'b1;
            w_state_nxt = c_st_hunt;
            w_idx_nxt   = 4'd0;
          end
        end

        default: begin
          w_state_nxt = c_st_hunt;
          w_idx_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Consecutive identical TS counter
  always_comb begin
    if (r_id == TS1_ID) begin
      w_type_new = TS_TYPE1;
    end else begin
      w_type_new = TS_TYPE2;
    end

    // At the completing edge the shadow already holds symbols 1..5.
    w_same = r_cmp_ok && (w_type_new == r_ts_type) && (r_shadow == r_fields);

    w_cnt_nxt    = r_cnt;
    w_cmp_ok_nxt = r_cmp_ok;
    if (w_ts_done) begin
      // The new TS becomes the reference even when a clear coincides.
      w_cmp_ok_nxt = 1'b1;
      if (!cnt_clr && w_same) begin
        w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;
      end else begin
        w_cnt_nxt = c_cnt_one;
      end
    end else if (w_abort || cnt_clr) begin
      w_cnt_nxt    = '0;
      w_cmp_ok_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_hunt;
      r_idx      <= 4'd0;
      r_shadow   <= '0;
      r_id       <= 8'd0;
      r_fields   <= '0;
      r_ts_type  <= TS_NONE;
      r_ts_valid <= 1'b0;
      r_eios     <= 1'b0;
      r_cnt      <= '0;
      r_hit      <= 1'b0;
      r_cmp_ok   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_shadow   <= w_shadow_nxt;
      r_id       <= w_id_nxt;
      r_ts_valid <= w_ts_done;
      r_eios     <= w_eios_done;
      r_cnt      <= w_cnt_nxt;
      r_hit      <= (w_cnt_nxt >= c_target);
      r_cmp_ok   <= w_cmp_ok_nxt;
      if (w_ts_done) begin
        r_fields  <= r_shadow;
        r_ts_type <= w_type_new;
      end
    end
  end

  assign ts_valid    = r_ts_valid;
  assign ts_type     = r_ts_type;
  assign ts_link_pad = r_fields.link_pad;
  assign ts_link_num = r_fields.link;
  assign ts_lane_pad = r_fields.lane_pad;
  assign ts_lane_num = r_fields.lane;
  assign ts_nfts     = r_fields.nfts;
  assign ts_rate     = r_fields.rate;
  assign ts_ctrl     = r_fields.ctrl;
  assign consec_cnt  = r_cnt;
  assign consec_hit  = r_hit;
  assign eios_det    = r_eios;

endmodule : ts_os_detect
`default_nettype wire
